// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and constants for the keypad code lock.
//   lock_state_t : controller states
//   deb_mode_t   : debouncer mode (qualify a press, or confirm a release)
//   bcd_t        : one BCD digit
//   DIGITS       : digits per code entry
//   BCD_MAX      : largest legal digit value
package keypad_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    COLLECT,
    WAIT_REL,
    CHECK,
    OPEN,
    LOCKED
  } lock_state_t;

  typedef enum logic {
    DEB_PRESS,
    DEB_RELEASE
  } deb_mode_t;

  localparam logic [2:0] DIGITS  = 3'd4;
  localparam bcd_t       BCD_MAX = 4'd9;

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer
// Counts consecutive stable keypad samples and fires a single-cycle strobe.
// In press mode it needs DEB_CYCLES samples of the same legal digit.
// In release mode it needs DEB_CYCLES samples with key_valid low.
// Ports:
//   clk, rst_n  : clock and synchronous active-low reset
//   enable      : when low, the count is cleared and no strobe is produced
//   mode        : DEB_PRESS or DEB_RELEASE
//   key_digit   : digit from the keypad decoder
//   key_valid   : decoder "key pressed" flag
//   strobe      : combinational; high on the sample that completes the run
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      enable,
  input  deb_mode_t mode,
  input  bcd_t      key_digit,
  input  logic      key_valid,
  output logic      strobe
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] cnt_d;
  bcd_t          prev_digit;
  logic          qualifying;
  logic          same_run;

  // The strobe is taken straight from the sample that completes the run so
  // the top can register the accepted digit on that same edge.
  always_comb begin
    qualifying = key_valid && (key_digit <= BCD_MAX);
    same_run   = (deb_cnt != '0) && (key_digit == prev_digit);
    cnt_d      = '0;
    strobe     = 1'b0;
    if (enable) begin
      if (mode == DEB_PRESS) begin
        if (qualifying) begin
          // A changed digit restarts the run but is itself the first sample.
          if (!same_run)                cnt_d  = CNT_ONE;
          else if (deb_cnt == CNT_LAST) strobe = 1'b1;
          else                          cnt_d  = deb_cnt + CNT_ONE;
        end
      end else if (!key_valid) begin
        if (deb_cnt == CNT_LAST) strobe = 1'b1;
        else                     cnt_d  = deb_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_cnt    <= '0;
      prev_digit <= '0;
    end else begin
      deb_cnt    <= cnt_d;
      prev_digit <= key_digit;
    end
  end

endmodule

// File: rtl/keypad_code_lock.sv
// keypad_code_lock
// Debounced 4-digit code entry with unlock window and failed-attempt lockout.
// Ports:
//   clk, rst_n      : clock and synchronous active-low reset
//   key_digit       : decoder digit, values above 9 are ignored
//   key_valid       : decoder "key pressed" flag
//   clear           : abort the current entry
//   entry           : BCD digits entered so far, newest in [3:0]
//   digits_entered  : number of digits held (0..4)
//   open            : unlock window active
//   err             : one-cycle pulse after a wrong code
//   locked          : lockout active
//   fails           : consecutive failed attempts
//
// state    | meaning
// COLLECT  | waiting for a debounced press
// WAIT_REL | waiting for a debounced release
// CHECK    | compare the 4-digit entry against CODE (one cycle)
// OPEN     | unlock window, keys ignored
// LOCKED   | lockout after MAX_FAILS wrong codes, keys and clear ignored
module keypad_code_lock
  import keypad_pkg::*;
#(
  parameter int          DEB_CYCLES  = 4,
  parameter logic [15:0] CODE        = 16'h1234,
  parameter int          OPEN_CYCLES = 8,
  parameter int          MAX_FAILS   = 3,
  parameter int          LOCK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_digit,
  input  logic        key_valid,
  input  logic        clear,
  output logic [15:0] entry,
  output logic [2:0]  digits_entered,
  output logic        open,
  output logic        err,
  output logic        locked,
  output logic [1:0]  fails
);

  localparam int            TMR_MAX    = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int            TW         = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    FAIL_LIMIT = 2'(MAX_FAILS);

  lock_state_t   state;
  lock_state_t   state_d;
  logic [15:0]   entry_q;
  logic [2:0]    digits_q;
  logic [1:0]    fails_q;
  logic          err_q;
  logic [TW-1:0] timer_q;

  logic          deb_enable;
  deb_mode_t     deb_mode;
  logic          deb_strobe;
  logic          code_match;
  logic [1:0]    fails_inc;
  logic          last_digit;

  // Clearing the debouncer on clear restarts any release count in progress.
  assign deb_enable = ((state == COLLECT) || (state == WAIT_REL)) && !clear;
  assign deb_mode   = (state == WAIT_REL) ? DEB_RELEASE : DEB_PRESS;
  assign code_match = (entry_q == CODE);
  assign fails_inc  = fails_q + 2'd1;
  assign last_digit = (digits_q == DIGITS - 3'd1);

  key_debouncer #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (deb_enable),
    .mode      (deb_mode),
    .key_digit (key_digit),
    .key_valid (key_valid),
    .strobe    (deb_strobe)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      COLLECT: begin
        if (clear)           state_d = WAIT_REL;
        else if (deb_strobe) state_d = last_digit ? CHECK : WAIT_REL;
      end
      WAIT_REL: begin
        if (deb_strobe) state_d = COLLECT;
      end
      CHECK: begin
        if (code_match)                  state_d = OPEN;
        else if (fails_inc == FAIL_LIMIT) state_d = LOCKED;
        else                              state_d = WAIT_REL;
      end
      OPEN, LOCKED: begin
        if (timer_q == '0) state_d = WAIT_REL;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    open           = (state == OPEN);
    locked         = (state == LOCKED);
    err            = err_q;
    entry          = entry_q;
    digits_entered = digits_q;
    fails          = fails_q;
  end

  // Timer is loaded with N-1 on entry so the window spans exactly N cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q  <= '0;
      digits_q <= '0;
      fails_q  <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        COLLECT: begin
          if (clear) begin
            entry_q  <= '0;
            digits_q <= '0;
          end else if (deb_strobe) begin
            entry_q  <= {entry_q[11:0], key_digit};
            digits_q <= digits_q + 3'd1;
          end
        end
        WAIT_REL: begin
          if (clear) begin
            entry_q  <= '0;
            digits_q <= '0;
          end
        end
        CHECK: begin
          entry_q  <= '0;
          digits_q <= '0;
          if (code_match) begin
            fails_q <= '0;
            timer_q <= OPEN_LOAD;
          end else begin
            err_q <= 1'b1;
            if (fails_inc == FAIL_LIMIT) begin
              fails_q <= '0;
              timer_q <= LOCK_LOAD;
            end else begin
              fails_q <= fails_inc;
            end
          end
        end
        OPEN, LOCKED: begin
          if (timer_q != '0) timer_q <= timer_q - TW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
